lift_platform_ctrl: RTL and testbench

//  Sequences one vertical lift platform from the level's purple pressure buttons.

---
 rtl/lift_platform_ctrl.sv | 138 +++++++++++++
 tb/tb_lift_platform_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lift_platform_ctrl.sv
// Lift platform sequencer: arbitrates button requests, raises, holds and lowers one platform.
// Latency: 1 Clk on every output; no backpressure (level inputs, outputs valid every cycle).
module lift_platform_ctrl #(
    parameter int NREQ        = 2,
    parameter int Y_TOP       = 178,
    parameter int Y_BOTTOM    = 251,
    parameter int STEP        = 1,
    parameter int HOLD_FRAMES = 30,
    localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_tick,
    input  logic [NREQ-1:0] btn_req,
    input  logic            obstruct,
    output logic [9:0]      plat_y,
    output logic            moving,
    output logic            at_top,
    output logic            at_bottom,
    output logic [OW-1:0]   owner,
    output logic            owner_vld
);

    typedef enum logic [2:0] {
        S_DOWN,
        S_RISE,
        S_UP,
        S_HOLD,
        S_FALL
    } state_t;

    localparam logic [9:0] YT       = 10'(Y_TOP);
    localparam logic [9:0] YB       = 10'(Y_BOTTOM);
    localparam logic [9:0] YS       = 10'(STEP);
    localparam logic [9:0] RISE_LIM = 10'(Y_TOP + STEP);
    localparam logic [9:0] FALL_LIM = 10'(Y_BOTTOM - STEP);
    localparam logic [7:0] HF       = 8'(HOLD_FRAMES);

    state_t        state_q, state_d;
    logic [9:0]    plat_y_d;
    logic [7:0]    hold_cnt, hold_cnt_d;
    logic [OW-1:0] owner_d, lowest_idx;
    logic          owner_vld_d;
    logic          req_any;
    logic [9:0]    y_up, y_dn;

    assign req_any = |btn_req;

    // Saturate against the limit before stepping so plat_y can never wrap.
    assign y_up = (plat_y <= RISE_LIM) ? YT : plat_y - YS;
    assign y_dn = (plat_y >= FALL_LIM) ? YB : plat_y + YS;

    always_comb begin
        state_d    = state_q;
        plat_y_d   = plat_y;
        hold_cnt_d = hold_cnt;
        case (state_q)
            S_DOWN: begin
                if (req_any) state_d = S_RISE;
            end
            S_RISE: begin
                if (!req_any) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HF;
                end else if (frame_tick) begin
                    plat_y_d = y_up;
                    if (y_up == YT) state_d = S_UP;
                end
            end
            S_UP: begin
                if (!req_any) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HF;
                end
            end
            S_HOLD: begin
                if (req_any) begin
                    state_d = at_top ? S_UP : S_RISE;
                end else if (hold_cnt == 8'd0) begin
                    state_d = S_FALL;
                end else if (frame_tick) begin
                    hold_cnt_d = hold_cnt - 8'd1;
                end
            end
            S_FALL: begin
                if (req_any) begin
                    state_d = S_RISE;
                end else if (frame_tick && !obstruct) begin
                    plat_y_d = y_dn;
                    if (y_dn == YB) state_d = S_DOWN;
                end
            end
            default: state_d = S_DOWN;
        endcase
    end

    always_comb begin
        lowest_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (btn_req[i]) lowest_idx = OW'(i);
        end
    end

    // No preemption: ownership only moves once the current owner lets go.
    always_comb begin
        owner_d     = owner;
        owner_vld_d = owner_vld;
        if (!owner_vld || !btn_req[owner]) begin
            if (req_any) begin
                owner_d     = lowest_idx;
                owner_vld_d = 1'b1;
            end else begin
                owner_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_DOWN;
            plat_y    <= YB;
            hold_cnt  <= 8'd0;
            owner     <= '0;
            owner_vld <= 1'b0;
        end else begin
            state_q   <= state_d;
            plat_y    <= plat_y_d;
            hold_cnt  <= hold_cnt_d;
            owner     <= owner_d;
            owner_vld <= owner_vld_d;
        end
    end

    assign moving    = (state_q == S_RISE) || (state_q == S_FALL);
    assign at_top    = (plat_y == YT);
    assign at_bottom = (plat_y == YB);

endmodule

// File: tb/tb_lift_platform_ctrl.sv
// Directed bench for lift_platform_ctrl: short vector table plus long rise/hold/fall sequences.
module tb_lift_platform_ctrl;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic [1:0] btn_req;
    logic       obstruct;
    logic [9:0] plat_y;
    logic       moving;
    logic       at_top;
    logic       at_bottom;
    logic       owner;
    logic       owner_vld;

    int checks = 0;
    int errors = 0;

    lift_platform_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .btn_req    (btn_req),
        .obstruct   (obstruct),
        .plat_y     (plat_y),
        .moving     (moving),
        .at_top     (at_top),
        .at_bottom  (at_bottom),
        .owner      (owner),
        .owner_vld  (owner_vld)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit         rst;
        bit         tick;
        logic [1:0] req;
        bit         obs;
        int         y;
        bit         mv;
        bit         top;
        bit         bot;
        int         own;
        bit         vld;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit tk, input logic [1:0] rq, input bit ob);
        Reset      = rst;
        frame_tick = tk;
        btn_req    = rq;
        obstruct   = ob;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        Reset = 1'b1; frame_tick = 1'b0; btn_req = 2'b00; obstruct = 1'b0;

        //            rst tk req    obs  y   mv top bot own vld
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 251, 1'b0, 1'b0, 1'b1, 0, 1'b0}; // reset
        tbl[1]  = '{1'b0, 1'b0, 2'b10, 1'b0, 251, 1'b1, 1'b0, 1'b1, 1, 1'b1}; // grant bit1, RISE
        tbl[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 250, 1'b1, 1'b0, 1'b0, 1, 1'b1}; // no preempt
        tbl[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 249, 1'b1, 1'b0, 1'b0, 0, 1'b1}; // hand over same cycle
        tbl[4]  = '{1'b0, 1'b0, 2'b10, 1'b0, 249, 1'b1, 1'b0, 1'b0, 1, 1'b1}; // hand back to 1
        tbl[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 249, 1'b0, 1'b0, 1'b0, 1, 1'b0}; // release beats tick
        tbl[6]  = '{1'b0, 1'b1, 2'b10, 1'b0, 249, 1'b1, 1'b0, 1'b0, 1, 1'b1}; // HOLD below top -> RISE
        tbl[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 248, 1'b1, 1'b0, 1'b0, 1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 2'b10, 1'b0, 251, 1'b0, 1'b0, 1'b1, 0, 1'b0}; // reset mid-rise
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 251, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 1'b1, 251, 1'b0, 1'b0, 1'b1, 0, 1'b0};

        for (int v = 0; v < 11; v++) begin
            step(tbl[v].rst, tbl[v].tick, tbl[v].req, tbl[v].obs);
            chk($sformatf("vec%0d plat_y", v), int'(plat_y), tbl[v].y);
            chk($sformatf("vec%0d moving", v), int'(moving), int'(tbl[v].mv));
            chk($sformatf("vec%0d at_top", v), int'(at_top), int'(tbl[v].top));
            chk($sformatf("vec%0d at_bottom", v), int'(at_bottom), int'(tbl[v].bot));
            chk($sformatf("vec%0d owner", v), int'(owner), tbl[v].own);
            chk($sformatf("vec%0d owner_vld", v), int'(owner_vld), int'(tbl[v].vld));
        end

        // Full rise: 73 ticks reach the top, extra ticks stay saturated.
        step(1'b0, 1'b0, 2'b01, 1'b0);
        chk("rise_start moving", int'(moving), 1);
        for (int k = 1; k <= 80; k++) begin
            step(1'b0, 1'b1, 2'b01, 1'b0);
            chk($sformatf("rise tick%0d plat_y", k), int'(plat_y), (251 - k > 178) ? 251 - k : 178);
        end
        chk("up at_top", int'(at_top), 1);
        chk("up moving", int'(moving), 0);
        chk("up owner", int'(owner), 0);
        chk("up owner_vld", int'(owner_vld), 1);

        // Release, 30-frame hold, descent with an obstruction at y=200.
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("hold owner_vld", int'(owner_vld), 0);
        chk("hold plat_y", int'(plat_y), 178);
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 2'b00, 1'b0);
            chk($sformatf("hold tick%0d moving", k), int'(moving), 0);
        end
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("hold_expire moving", int'(moving), 1);
        chk("hold_expire plat_y", int'(plat_y), 178);
        for (int k = 1; k <= 22; k++) begin
            step(1'b0, 1'b1, 2'b00, 1'b0);
            chk($sformatf("fall tick%0d plat_y", k), int'(plat_y), 178 + k);
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 2'b00, 1'b1);
            chk($sformatf("obstruct%0d plat_y", k), int'(plat_y), 200);
            chk($sformatf("obstruct%0d moving", k), int'(moving), 1);
        end
        for (int k = 1; k <= 51; k++) begin
            step(1'b0, 1'b1, 2'b00, 1'b0);
            chk($sformatf("resume tick%0d plat_y", k), int'(plat_y), 200 + k);
        end
        chk("down moving", int'(moving), 0);
        chk("down at_bottom", int'(at_bottom), 1);
        chk("down owner_vld", int'(owner_vld), 0);

        // Re-press during HOLD at the top goes to UP and the next release reloads the counter.
        step(1'b0, 1'b0, 2'b01, 1'b0);
        for (int k = 1; k <= 73; k++) step(1'b0, 1'b1, 2'b01, 1'b0);
        chk("rise2 at_top", int'(at_top), 1);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        for (int k = 1; k <= 25; k++) step(1'b0, 1'b1, 2'b00, 1'b0);
        chk("hold5 moving", int'(moving), 0);
        step(1'b0, 1'b0, 2'b01, 1'b0);
        chk("repress moving", int'(moving), 0);
        chk("repress at_top", int'(at_top), 1);
        chk("repress owner_vld", int'(owner_vld), 1);
        chk("repress owner", int'(owner), 0);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 2'b00, 1'b0);
            chk($sformatf("reload tick%0d moving", k), int'(moving), 0);
        end
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("reload_expire moving", int'(moving), 1);
        chk("reload_expire plat_y", int'(plat_y), 178);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
